// File: rtl/idct_sequencer.sv
// -----------------------------------------------------------------------------
// idct_sequencer
//
// Cycle-level controller for the 8x8 IDCT datapath (Y = AT*X*A). It performs
// no arithmetic itself. It loads one 64-word block into the X buffer, runs two
// matrix passes through the shared MAC, then streams the Y buffer out under
// valid/ready.
//
// Configuration macro: IDCT_SEQ_PRELOAD_EN
//   When defined, the next block may be loaded during PASS2/DRAIN2/OUT.
//   The X buffer is idle during those states.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   i_in_valid       input beat valid (raster order)
//   o_in_ready       input beat ready
//   o_x_wr_en        X-buffer write strobe, one cycle after the accepted beat
//   o_x_wr_addr      X-buffer write address
//   o_rom_addr       AT coefficient ROM address (synchronous read)
//   o_src_sel        MAC operand source: 0 = X, 1 = MT
//   o_src_addr       MAC operand address (synchronous read)
//   o_mac_en         accumulate enable
//   o_mac_clr        with o_mac_en, load the product instead of adding it
//   o_dst_wr_en      accumulator write strobe
//   o_dst_sel        0 = MT (full width), 1 = Y (scaled by the datapath)
//   o_dst_addr       accumulator write address
//   o_out_valid      Y output valid
//   i_out_ready      Y output ready
//   o_out_last       marks Y element 63
//   o_y_rd_addr      Y-buffer read address (combinational-read buffer)
//   o_busy           high outside IDLE/LOAD
//   o_done           one-cycle pulse after the final output beat
//   o_blk_cnt        completed-block counter (wraps)
// -----------------------------------------------------------------------------
module idct_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_x_wr_en,
  output logic [5:0]  o_x_wr_addr,
  output logic [5:0]  o_rom_addr,
  output logic        o_src_sel,
  output logic [5:0]  o_src_addr,
  output logic        o_mac_en,
  output logic        o_mac_clr,
  output logic        o_dst_wr_en,
  output logic        o_dst_sel,
  output logic [5:0]  o_dst_addr,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic [5:0]  o_y_rd_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_blk_cnt
);

  // Only N = 8 is supported. There are 512 terms per pass (64 outputs x 8 products).
  localparam logic [8:0] LP_LAST_TERM = 9'(N * N * N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PASS1  = 3'd2,
    S_DRAIN1 = 3'd3,
    S_PASS2  = 3'd4,
    S_DRAIN2 = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic [5:0]  r_ld_cnt;
  logic        r_x_wr_en;
  logic [5:0]  r_x_wr_addr;
  logic [8:0]  r_term;      // {m, k}, where m = 8r + c
  logic        r_drn;
  logic [5:0]  r_rom_addr;
  logic [5:0]  r_src_addr;
  logic        r_src_sel;
  logic        r_mac_en;
  logic        r_mac_clr;
  logic        r_wb_pend;   // stage between the MAC enable and the write-back
  logic        r_wb_sel;
  logic [5:0]  r_wb_addr;
  logic        r_dst_wr_en;
  logic        r_dst_sel;
  logic [5:0]  r_dst_addr;
  logic        r_out_valid;
  logic        r_out_last;
  logic [5:0]  r_y_rd_addr;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_blk_cnt;
`ifdef IDCT_SEQ_PRELOAD_EN
  logic        r_pre_full;  // 64 beats already preloaded for the next block
`endif

  logic       w_accept;
  logic       w_ld_wrap;
  logic       w_in_pass;
  logic       w_out_fire;
  logic       w_out_end;
  logic [8:0] w_term_nxt;

  assign w_accept   = i_in_valid & r_in_ready;
  assign w_ld_wrap  = w_accept & (r_ld_cnt == 6'd63);
  assign w_in_pass  = (r_state == S_PASS1) || (r_state == S_PASS2);
  assign w_out_fire = r_out_valid & i_out_ready;
  assign w_out_end  = w_out_fire & (r_y_rd_addr == 6'd63);
  assign w_term_nxt = r_term + 9'd1;

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_ld_cnt    <= 6'd0;
      r_x_wr_en   <= 1'b0;
      r_x_wr_addr <= 6'd0;
      r_term      <= 9'd0;
      r_drn       <= 1'b0;
      r_rom_addr  <= 6'd0;
      r_src_addr  <= 6'd0;
      r_src_sel   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_wb_pend   <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_wb_addr   <= 6'd0;
      r_dst_wr_en <= 1'b0;
      r_dst_sel   <= 1'b0;
      r_dst_addr  <= 6'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_y_rd_addr <= 6'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blk_cnt   <= 16'd0;
`ifdef IDCT_SEQ_PRELOAD_EN
      r_pre_full  <= 1'b0;
`endif
    end else begin
      // The X write lands one cycle after acceptance. The datapath registers
      // the input beat alongside this strobe.
      r_x_wr_en <= w_accept;
      if (w_accept) begin
        r_x_wr_addr <= r_ld_cnt;
        r_ld_cnt    <= r_ld_cnt + 6'd1;   // wraps to 0 on beat 64
      end

      // MAC pipeline: address at t, accumulate at t+1, write-back at t+2.
      r_mac_en    <= w_in_pass;
      r_mac_clr   <= w_in_pass && (r_term[2:0] == 3'd0);
      r_wb_pend   <= w_in_pass && (r_term[2:0] == 3'd7);
      r_wb_addr   <= r_term[8:3];
      r_wb_sel    <= (r_state == S_PASS2);
      r_dst_wr_en <= r_wb_pend;
      if (r_wb_pend) begin
        r_dst_addr <= r_wb_addr;
        r_dst_sel  <= r_wb_sel;
      end

      r_done <= 1'b0;

`ifdef IDCT_SEQ_PRELOAD_EN
      // The preload buffer is full. Refuse further beats until the next block starts.
      if (w_ld_wrap && ((r_state == S_PASS2) || (r_state == S_DRAIN2) || (r_state == S_OUT))) begin
        r_pre_full <= 1'b1;
        r_in_ready <= 1'b0;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (w_ld_wrap) begin
            r_state    <= S_PASS1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_term     <= 9'd0;
            r_rom_addr <= 6'd0;
            r_src_addr <= 6'd0;
            r_src_sel  <= 1'b0;
          end else begin
            r_state <= S_LOAD;
          end
        end

        S_PASS1, S_PASS2: begin
          if (r_term == LP_LAST_TERM) begin
            r_state <= (r_state == S_PASS1) ? S_DRAIN1 : S_DRAIN2;
            r_drn   <= 1'b0;
          end else begin
            // Here m = {r, c} and the term index is {r, c, k}.
            // rom_addr = 8c + k and src_addr = 8k + r.
            r_term     <= w_term_nxt;
            r_rom_addr <= w_term_nxt[5:0];
            r_src_addr <= {w_term_nxt[2:0], w_term_nxt[8:6]};
          end
        end

        S_DRAIN1: begin
          if (r_drn) begin
            r_state    <= S_PASS2;
            r_term     <= 9'd0;
            r_rom_addr <= 6'd0;
            r_src_addr <= 6'd0;
            r_src_sel  <= 1'b1;
`ifdef IDCT_SEQ_PRELOAD_EN
            r_in_ready <= 1'b1;
`else
            r_in_ready <= 1'b0;
`endif
          end else begin
            r_drn <= 1'b1;
          end
        end

        S_DRAIN2: begin
          if (r_drn) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_y_rd_addr <= 6'd0;
          end else begin
            r_drn <= 1'b1;
          end
        end

        S_OUT: begin
          if (w_out_end) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_y_rd_addr <= 6'd0;
            r_done      <= 1'b1;
            r_blk_cnt   <= r_blk_cnt + 16'd1;
`ifdef IDCT_SEQ_PRELOAD_EN
            if (r_pre_full || w_ld_wrap) begin
              // A full block is already buffered. Start computing it immediately.
              r_state    <= S_PASS1;
              r_pre_full <= 1'b0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_term     <= 9'd0;
              r_rom_addr <= 6'd0;
              r_src_addr <= 6'd0;
              r_src_sel  <= 1'b0;
            end else if (w_accept || (r_ld_cnt != 6'd0)) begin
              r_state    <= S_LOAD;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
`else
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
`endif
          end else if (w_out_fire) begin
            r_y_rd_addr <= r_y_rd_addr + 6'd1;
            r_out_last  <= (r_y_rd_addr == 6'd62);
          end else begin
            r_state <= S_OUT;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_x_wr_en   = r_x_wr_en;
  assign o_x_wr_addr = r_x_wr_addr;
  assign o_rom_addr  = r_rom_addr;
  assign o_src_sel   = r_src_sel;
  assign o_src_addr  = r_src_addr;
  assign o_mac_en    = r_mac_en;
  assign o_mac_clr   = r_mac_clr;
  assign o_dst_wr_en = r_dst_wr_en;
  assign o_dst_sel   = r_dst_sel;
  assign o_dst_addr  = r_dst_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_y_rd_addr = r_y_rd_addr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_idct_sequencer.sv
// -----------------------------------------------------------------------------
// tb_idct_sequencer
//
// Directed bench for idct_sequencer. A small behavioural model of the IDCT
// datapath (ROM, X/MT/Y buffers, MAC) is driven by the sequencer strobes. The
// expected results were computed by hand.
// -----------------------------------------------------------------------------
module tb_idct_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        o_x_wr_en;
  logic [5:0]  o_x_wr_addr;
  logic [5:0]  o_rom_addr;
  logic        o_src_sel;
  logic [5:0]  o_src_addr;
  logic        o_mac_en;
  logic        o_mac_clr;
  logic        o_dst_wr_en;
  logic        o_dst_sel;
  logic [5:0]  o_dst_addr;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_out_last;
  logic [5:0]  o_y_rd_addr;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_blk_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  idct_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_x_wr_en   (o_x_wr_en),
    .o_x_wr_addr (o_x_wr_addr),
    .o_rom_addr  (o_rom_addr),
    .o_src_sel   (o_src_sel),
    .o_src_addr  (o_src_addr),
    .o_mac_en    (o_mac_en),
    .o_mac_clr   (o_mac_clr),
    .o_dst_wr_en (o_dst_wr_en),
    .o_dst_sel   (o_dst_sel),
    .o_dst_addr  (o_dst_addr),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (o_out_last),
    .o_y_rd_addr (o_y_rd_addr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_blk_cnt   (o_blk_cnt)
  );

  always #5 clk = ~clk;

  // Datapath model. Only the k = 0 coefficients (the DC basis, 90 in Q8)
  // matter for a block with only X[0] nonzero. The other entries are fillers.
  int rom_m [64];
  int x_m   [64];
  int mt_m  [64];
  int y_m   [64];
  int rom_q, src_q, acc, x_pipe, tb_data;

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_m[i] = ((i % 8) == 0) ? 90 : (i - 20);
      x_m[i]   = 0;
      mt_m[i]  = 0;
      y_m[i]   = 0;
    end
  end

  always @(posedge clk) begin
    rom_q <= rom_m[o_rom_addr];
    src_q <= o_src_sel ? mt_m[o_src_addr] : x_m[o_src_addr];
    if (o_mac_en) acc <= o_mac_clr ? rom_q * src_q : acc + rom_q * src_q;
    if (o_dst_wr_en) begin
      if (o_dst_sel) y_m[o_dst_addr] <= acc / 65536;
      else           mt_m[o_dst_addr] <= acc;
    end
    if (i_in_valid && o_in_ready) x_pipe <= tb_data;
    if (o_x_wr_en) x_m[o_x_wr_addr] <= x_pipe;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int accepted;
    int ph;
    int bad_addr, bad_last, bad_data, bad_valid, bad_strobe;
    int in_acc, rdy_seen;

    rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; tb_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", o_in_ready, 1);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_out_valid", o_out_valid, 0);
    check_eq("rst_blk_cnt", o_blk_cnt, 0);
    check_eq("rst_x_wr_en", o_x_wr_en, 0);
    rst_n = 1'b1;
    tick();

    // Load a block with X[0] = 64 and every other element 0, back-to-back.
    bad_addr = 0;
    for (int i = 0; i < 64; i++) begin
      i_in_valid = 1'b1;
      tb_data = (i == 0) ? 64 : 0;
      tick();
      if (!(o_x_wr_en && (o_x_wr_addr == 6'(i)))) bad_addr++;
    end
    i_in_valid = 1'b0;
    check_eq("load_wr_addr_seq", bad_addr, 0);
    check_eq("load_in_ready_drop", o_in_ready, 0);
    check_eq("load_busy", o_busy, 1);

    // Run the compute phase. cyc counts cycles since PASS1 entry.
    cyc = 0;
    while (!o_out_valid && cyc < 2000) begin
      if (cyc == 0) begin
        check_eq("p1_rom_t0", o_rom_addr, 0);
        check_eq("p1_src_t0", o_src_addr, 0);
        check_eq("p1_mac_en_t0", o_mac_en, 0);
      end
      if (cyc == 1) begin
        check_eq("p1_rom_t1", o_rom_addr, 1);
        check_eq("p1_src_t1", o_src_addr, 8);
        check_eq("p1_mac_en_t1", o_mac_en, 1);
        check_eq("p1_mac_clr_t1", o_mac_clr, 1);
      end
      if (cyc == 2) check_eq("p1_mac_clr_t2", o_mac_clr, 0);
      if (cyc == 8) check_eq("p1_dst_wr_c8", o_dst_wr_en, 0);
      if (cyc == 9) begin
        check_eq("p1_dst_wr_c9", o_dst_wr_en, 1);
        check_eq("p1_dst_addr_c9", o_dst_addr, 0);
        check_eq("p1_dst_sel_c9", o_dst_sel, 0);
      end
      if (cyc == 72) begin
        check_eq("p1_m9_rom_first", o_rom_addr, 8);
        check_eq("p1_m9_src_first", o_src_addr, 1);
      end
      if (cyc == 79) begin
        check_eq("p1_m9_rom_last", o_rom_addr, 15);
        check_eq("p1_m9_src_last", o_src_addr, 57);
      end
      if (cyc == 513) begin
        check_eq("drain1_dst_wr", o_dst_wr_en, 1);
        check_eq("drain1_dst_addr", o_dst_addr, 63);
        check_eq("drain1_mac_en", o_mac_en, 0);
      end
      if (cyc == 514) begin
        check_eq("p2_src_sel", o_src_sel, 1);
        check_eq("p2_rom_t0", o_rom_addr, 0);
      end
      if (cyc == 1027) begin
        check_eq("drain2_dst_wr", o_dst_wr_en, 1);
        check_eq("drain2_dst_sel", o_dst_sel, 1);
        check_eq("drain2_dst_addr", o_dst_addr, 63);
      end
      tick();
      cyc++;
    end
    check_eq("first_out_valid_cycle", cyc, 1028);

    // Output stream with out_ready toggling 1,0,1,0,...
    accepted = 0; ph = 0;
    bad_addr = 0; bad_last = 0; bad_data = 0; bad_valid = 0; bad_strobe = 0;
    while (accepted < 64 && ph < 400) begin
      i_out_ready = ((ph % 2) == 0);
      if (!o_out_valid) bad_valid++;
      if (o_y_rd_addr != 6'(accepted)) bad_addr++;
      if (o_out_last != (o_y_rd_addr == 6'd63)) bad_last++;
      if (o_mac_en || o_dst_wr_en || o_x_wr_en) bad_strobe++;
      if (o_out_valid && i_out_ready) begin
        if (y_m[o_y_rd_addr] != 7) bad_data++;
        accepted++;
      end
      tick();
      ph++;
    end
    i_out_ready = 1'b0;
    check_eq("out_accepted", accepted, 64);
    check_eq("out_valid_held", bad_valid, 0);
    check_eq("out_addr_stable", bad_addr, 0);
    check_eq("out_last_pos", bad_last, 0);
    check_eq("out_y_data", bad_data, 0);
    check_eq("out_no_strobes", bad_strobe, 0);
    check_eq("done_pulse", o_done, 1);
    check_eq("blk_cnt_1", o_blk_cnt, 1);
    check_eq("idle_busy", o_busy, 0);
    check_eq("idle_in_ready", o_in_ready, 1);
    tick();
    check_eq("done_clears", o_done, 0);

    // Assert reset in the middle of computing.
    for (int i = 0; i < 64; i++) begin
      i_in_valid = 1'b1;
      tb_data = 0;
      tick();
    end
    i_in_valid = 1'b0;
    repeat (700) tick();
    check_eq("pre_rst_src_sel", o_src_sel, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_in_ready", o_in_ready, 1);
    check_eq("async_rst_busy", o_busy, 0);
    check_eq("async_rst_src_sel", o_src_sel, 0);
    check_eq("async_rst_rom", o_rom_addr, 0);
    check_eq("async_rst_mac_en", o_mac_en, 0);
    check_eq("async_rst_blk_cnt", o_blk_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_in_valid = 1'b1;
    tick();
    check_eq("reload_wr_en", o_x_wr_en, 1);
    check_eq("reload_wr_addr", o_x_wr_addr, 0);
    repeat (63) tick();
    i_in_valid = 1'b0;
    check_eq("reload_busy", o_busy, 1);

    // Stream the next block while PASS2 runs.
    cyc = 0; in_acc = 0; rdy_seen = 0;
    i_out_ready = 1'b1;
    while (!o_done && cyc < 1200) begin
      i_in_valid = (cyc >= 514);
      if (i_in_valid && o_in_ready) in_acc++;
      if (o_in_ready) rdy_seen++;
      tick();
      cyc++;
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b0;
    check_eq("block_period_to_done", cyc, 1092);
    check_eq("blk_cnt_after_rst", o_blk_cnt, 1);
`ifdef IDCT_SEQ_PRELOAD_EN
    check_eq("preload_accepted", in_acc, 64);
    check_eq("preload_busy_at_done", o_busy, 1);
    check_eq("preload_rom_t0", o_rom_addr, 0);
    tick();
    check_eq("preload_rom_t1", o_rom_addr, 1);
    check_eq("preload_src_t1", o_src_addr, 8);
`else
    check_eq("no_preload_accepted", in_acc, 0);
    check_eq("no_preload_ready_seen", rdy_seen, 0);
    check_eq("no_preload_idle_ready", o_in_ready, 1);
    check_eq("no_preload_idle_busy", o_busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
